dmem_wb_arbiter: RTL and testbench
==================================

// Module: dmem_wb_arbiter
// PURPOSE
//  Shares the single-port data memory between the EX/WB stage (accumulator-CPU store path) and an external
//  debug/DMA requester. Sequences each access over a ready-handshake memory, stalls the pipeline (freezes EX/WB)
//  until its store completes, and aborts hung accesses by timeout. Sits between the EX/WB register outputs and dmem.
// PARAMETERS
//  AW          8   address width
//  DW          8   data width
//  MAX_WAIT    15  cycles in a BUSY state without mem_ready before abort (>=1)
//  STARVE_LIM  8   ext wait cycles before aging promotes ext (only with DMEM_ARB_AGING_EN)
// PORTS
//  clk         in   1   clock; all state changes on rising edge
//  rst         in   1   reset, synchronous, active-high
//  wb_req      in   1   store request from EX/WB (its mem_we output); held while wb_stall=1
//  wb_addr     in   AW  store address (EX/WB alu result)
//  wb_wdata    in   DW  store data (EX/WB data/acc)
//  wb_stall    out  1   freeze EX/WB and upstream; = wb_req & ~(state==RESP & owner==WB)
//  wb_done     out  1   1-cycle pulse: WB store finished
//  ext_valid   in   1   external request; addr/we/wdata stable until ext_ready
//  ext_we      in   1   1=write, 0=read
//  ext_addr    in   AW  external address
//  ext_wdata   in   DW  external write data
//  ext_ready   out  1   1-cycle pulse: external access finished
//  ext_rdata   out  DW  read data, valid while ext_ready=1; holds until next ext completion
//  ext_err     out  1   with ext_ready: access was aborted by timeout
//  mem_req     out  1   memory request; addr/we/wdata stable while high
//  mem_we      out  1   memory write enable
//  mem_addr    out  AW  memory address
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory read data, sampled when mem_ready=1
//  mem_ready   in   1   memory completion; ignored unless mem_req=1
//  err_timeout out  1   sticky; set on any abort, cleared by err_clr (set wins if same cycle)
//  err_clr     in   1   clear err_timeout
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, owner=WB, every output and counter 0; a cycle with rst=1 drops mem_req on the next edge,
//    in-flight access dropped with no done/ready pulse; the requester re-presents it after reset.
//  - States: IDLE -> WB_BUSY | EXT_BUSY -> RESP -> IDLE. All outputs registered except wb_stall.
//  - IDLE: wb_req wins over ext_valid (simultaneous -> WB); latch addr/we/wdata into mem_* and raise mem_req next cycle.
//  - BUSY: hold mem_* stable; on mem_ready=1 capture mem_rdata (ext read) and go RESP. Wait counter increments
//    each cycle mem_ready=0; at MAX_WAIT go RESP with abort (mem_req low, err_timeout set, ext_err=1 if ext).
//    mem_ready on the MAX_WAIT cycle = normal completion, no error.
//  - RESP: mem_req=0; pulse wb_done or ext_ready/ext_err for the owner; no arbitration; wb_stall low this cycle
//    for WB owner so EX/WB advances. Next state IDLE.
//  - Min access: request seen at edge N, mem_req=1 from N+1, mem_ready at N+1 -> done pulse at N+2, IDLE at N+3.
//  - WB stores always mem_we=1; WB never reads. Abort of WB store still completes it (wb_done) with err_timeout set.
//  - Aging counter: counts cycles ext_valid=1 while not granted; cleared on ext grant; saturates at STARVE_LIM.
// CONFIGURATION
//  DMEM_ARB_AGING_EN defined: in IDLE, if aging count == STARVE_LIM, ext wins over wb_req.
//  Not defined: strict WB priority, ext may starve indefinitely; aging counter not built.
// STRUCTURE
//  Package dmem_arb_pkg: arb_state_e {IDLE,WB_BUSY,EXT_BUSY,RESP}, arb_owner_e {OWN_WB,OWN_EXT}, default AW/DW.
//  Sub-module arb_wait_timer: load/clear on grant, count while busy & ~mem_ready, expire at MAX_WAIT.
// TESTING
//  1 wb_req=1 addr=0x12 data=0xA5, mem_ready 1 cycle after mem_req -> mem write 0x12/0xA5, wb_done 1 pulse, stall drops in RESP.
//  2 ext read addr=0x40, mem_rdata=0x3C, mem_ready after 3 cycles -> ext_ready pulse, ext_rdata=0x3C, ext_err=0.
//  3 wb_req and ext_valid same cycle -> WB access first, ext granted after RESP; both complete once.
//  4 mem_ready never asserts, MAX_WAIT=15 -> abort 15 cycles after mem_req rise, err_timeout=1 until err_clr.
//  5 rst=1 mid-BUSY -> mem_req 0 next cycle, no done/ready pulse, all outputs 0, IDLE.
//  6 AGING_EN, wb_req held continuously, ext_valid=1 -> ext granted once aging count reaches 8; without macro never.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data-memory arbiter
package dmem_arb_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WB_BUSY  = 2'd1,
        EXT_BUSY = 2'd2,
        RESP     = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_WB  = 1'b0,
        OWN_EXT = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_wait_timer.sv
// rtl/arb_wait_timer.sv - counts stalled memory cycles and flags the cycle an access must be aborted
module arb_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expire_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry is the MAX_WAIT-th stalled cycle; a ready in that same cycle still completes normally.
    assign expire_o = count_en_i && (cnt_q == CW'(MAX_WAIT - 1));

    // Restart on every grant, advance once per cycle the memory holds off.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_wb_arbiter.sv
// rtl/dmem_wb_arbiter.sv - dmem arbiter for EX/WB stores and external access; DMEM_ARB_AGING_EN enables ext aging
module dmem_wb_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int MAX_WAIT   = 15,
    parameter int STARVE_LIM = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_req,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_wdata,
    output logic          wb_stall,
    output logic          wb_done,
    input  logic          ext_valid,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ready,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err_timeout,
    input  logic          err_clr,
    output logic          busy
);
    if (MAX_WAIT < 1 || STARVE_LIM < 1) begin : g_param_check
        $error("dmem_wb_arbiter: MAX_WAIT and STARVE_LIM must be at least 1");
    end

    arb_state_e    state_q;
    arb_owner_e    owner_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          wb_done_q;
    logic          ext_ready_q;
    logic          ext_err_q;
    logic [DW-1:0] ext_rdata_q;
    logic          err_q;
    logic          busy_q;

    logic in_busy;
    logic grant_wb;
    logic grant_ext;
    logic timer_expire;

    assign in_busy = (state_q == WB_BUSY) || (state_q == EXT_BUSY);

`ifdef DMEM_ARB_AGING_EN
    localparam int AGE_W = $clog2(STARVE_LIM + 1);

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;
    logic             ext_active;
    logic             age_full;

    assign ext_active = (state_q == EXT_BUSY) || ((state_q == RESP) && (owner_q == OWN_EXT));
    assign age_full   = (age_q == AGE_W'(STARVE_LIM));
    assign grant_ext  = (state_q == IDLE) && ext_valid && (!wb_req || age_full);
    assign grant_wb   = (state_q == IDLE) && wb_req && !grant_ext;

    // Age a waiting external request; a full count lets it jump ahead of the store path.
    always_comb begin
        age_d = age_q;
        if (grant_ext) begin
            age_d = '0;
        end else if (ext_valid && !ext_active && !age_full) begin
            age_d = age_q + 1'b1;
        end
    end

    // Aging counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign grant_wb  = (state_q == IDLE) && wb_req;
    assign grant_ext = (state_q == IDLE) && ext_valid && !wb_req;
`endif

    arb_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (grant_wb || grant_ext),
        .count_en_i(in_busy && !mem_ready),
        .expire_o  (timer_expire)
    );

    // Access sequencer: grant, hold the memory request, then one response cycle per access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_WB;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_done_q   <= 1'b0;
            ext_ready_q <= 1'b0;
            ext_err_q   <= 1'b0;
            ext_rdata_q <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wb_done_q   <= 1'b0;
            ext_ready_q <= 1'b0;
            ext_err_q   <= 1'b0;
            if (err_clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (grant_wb) begin
                        state_q     <= WB_BUSY;
                        owner_q     <= OWN_WB;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wb_addr;
                        mem_wdata_q <= wb_wdata;
                        busy_q      <= 1'b1;
                    end else if (grant_ext) begin
                        state_q     <= EXT_BUSY;
                        owner_q     <= OWN_EXT;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= ext_we;
                        mem_addr_q  <= ext_addr;
                        mem_wdata_q <= ext_wdata;
                        busy_q      <= 1'b1;
                    end
                end
                WB_BUSY, EXT_BUSY: begin
                    if (mem_ready || timer_expire) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        if (state_q == WB_BUSY) begin
                            wb_done_q <= 1'b1;
                        end else begin
                            ext_ready_q <= 1'b1;
                            ext_err_q   <= timer_expire;
                            if (mem_ready && !mem_we_q) begin
                                ext_rdata_q <= mem_rdata;
                            end
                        end
                        if (timer_expire) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_stall    = wb_req && !((state_q == RESP) && (owner_q == OWN_WB));
    assign wb_done     = wb_done_q;
    assign ext_ready   = ext_ready_q;
    assign ext_err     = ext_err_q;
    assign ext_rdata   = ext_rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign err_timeout = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dmem_wb_arbiter.sv
// tb/tb_dmem_wb_arbiter.sv - self-checking bench for dmem_wb_arbiter (aging expectations follow DMEM_ARB_AGING_EN)
module tb_dmem_wb_arbiter;
    localparam int NCYC     = 116;
    localparam int MAX_WAIT = 15;

    logic       clk;
    logic       rst;
    logic       wb_req;
    logic [7:0] wb_addr;
    logic [7:0] wb_wdata;
    logic       wb_stall;
    logic       wb_done;
    logic       ext_valid;
    logic       ext_we;
    logic [7:0] ext_addr;
    logic [7:0] ext_wdata;
    logic       ext_ready;
    logic [7:0] ext_rdata;
    logic       ext_err;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       err_timeout;
    logic       err_clr;
    logic       busy;

    dmem_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .wb_req     (wb_req),
        .wb_addr    (wb_addr),
        .wb_wdata   (wb_wdata),
        .wb_stall   (wb_stall),
        .wb_done    (wb_done),
        .ext_valid  (ext_valid),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_ready  (ext_ready),
        .ext_rdata  (ext_rdata),
        .ext_err    (ext_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .err_timeout(err_timeout),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle stimulus table
    logic       in_rst       [NCYC];
    logic       in_wb_req    [NCYC];
    logic [7:0] in_wb_addr   [NCYC];
    logic [7:0] in_wb_wdata  [NCYC];
    logic       in_ext_valid [NCYC];
    logic       in_ext_we    [NCYC];
    logic [7:0] in_ext_addr  [NCYC];
    logic [7:0] in_ext_wdata [NCYC];
    logic       in_mem_ready [NCYC];
    logic [7:0] in_mem_rdata [NCYC];
    logic       in_err_clr   [NCYC];

    // Per-cycle expected timeline derived from access latencies
    logic       ex_mem_req   [NCYC];
    logic       ex_mem_we    [NCYC];
    logic [7:0] ex_mem_addr  [NCYC];
    logic [7:0] ex_mem_wdata [NCYC];
    logic       ex_busy      [NCYC];
    logic       ex_wb_done   [NCYC];
    logic       ex_resp_wb   [NCYC];
    logic       ex_ext_ready [NCYC];
    logic       ex_ext_err   [NCYC];
    logic       ex_err_set   [NCYC];
    int         ex_rd_ev     [NCYC];
    logic [7:0] ex_rd_val    [NCYC];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic       m_err      = 1'b0;
    logic       m_rd_known = 1'b0;
    logic [7:0] m_rd_val   = 8'h00;

    function automatic void cmp(string name, int c, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    endfunction

    // kind: 0 = WB store, 1 = ext read, 2 = ext write; d >= MAX_WAIT means memory never answers.
    // Request held from cycle p; arbiter idle and grants from cycle r. Returns the response cycle.
    function automatic int access(int p, int r, int kind, logic [7:0] addr, logic [7:0] data,
                                  int d, logic [7:0] rd);
        bit abort = (d >= MAX_WAIT);
        int len   = abort ? MAX_WAIT : d + 1;
        int resp  = r + len + 1;
        for (int c = p; c <= resp; c++) begin
            if (kind == 0) begin
                in_wb_req[c] = 1'b1; in_wb_addr[c] = addr; in_wb_wdata[c] = data;
            end else begin
                in_ext_valid[c] = 1'b1; in_ext_we[c] = (kind == 2);
                in_ext_addr[c] = addr; in_ext_wdata[c] = data;
            end
        end
        for (int c = r + 1; c <= r + len; c++) begin
            ex_mem_req[c] = 1'b1; ex_mem_we[c] = (kind != 1);
            ex_mem_addr[c] = addr; ex_mem_wdata[c] = data;
        end
        for (int c = r + 1; c <= resp; c++) ex_busy[c] = 1'b1;
        if (!abort) begin
            in_mem_ready[r + len] = 1'b1;
            in_mem_rdata[r + len] = rd;
        end
        if (kind == 0) begin
            ex_wb_done[resp] = 1'b1; ex_resp_wb[resp] = 1'b1;
        end else begin
            ex_ext_ready[resp] = 1'b1; ex_ext_err[resp] = abort;
            ex_rd_ev[resp] = (kind == 1 && !abort) ? 1 : 2;
            ex_rd_val[resp] = rd;
        end
        if (abort) ex_err_set[resp] = 1'b1;
        return resp;
    endfunction

    function automatic void kill(int rc, int upto);
        in_rst[rc] = 1'b1;
        for (int c = rc; c <= upto; c++) begin
            in_wb_req[c] = 1'b0; in_ext_valid[c] = 1'b0;
            in_mem_ready[c] = 1'b0; in_err_clr[c] = 1'b0;
        end
        for (int c = rc + 1; c <= upto; c++) begin
            ex_mem_req[c] = 1'b0; ex_busy[c] = 1'b0; ex_wb_done[c] = 1'b0;
            ex_resp_wb[c] = 1'b0; ex_ext_ready[c] = 1'b0; ex_ext_err[c] = 1'b0;
            ex_err_set[c] = 1'b0; ex_rd_ev[c] = 0;
        end
    endfunction

    task automatic apply(int c);
        rst = in_rst[c]; wb_req = in_wb_req[c]; wb_addr = in_wb_addr[c]; wb_wdata = in_wb_wdata[c];
        ext_valid = in_ext_valid[c]; ext_we = in_ext_we[c]; ext_addr = in_ext_addr[c];
        ext_wdata = in_ext_wdata[c]; mem_ready = in_mem_ready[c]; mem_rdata = in_mem_rdata[c];
        err_clr = in_err_clr[c];
    endtask

    // Model state update plus full output comparison for one cycle.
    task automatic check_cycle(int c);
        if (in_rst[c-1]) begin
            m_err = 1'b0; m_rd_known = 1'b1; m_rd_val = 8'h00;
        end else begin
            if (ex_err_set[c]) m_err = 1'b1;
            else if (in_err_clr[c-1]) m_err = 1'b0;
            if (ex_rd_ev[c] == 1) begin
                m_rd_known = 1'b1; m_rd_val = ex_rd_val[c];
            end else if (ex_rd_ev[c] == 2) begin
                m_rd_known = 1'b0;
            end
        end
        cmp("mem_req", c, 32'(mem_req), 32'(ex_mem_req[c]));
        cmp("busy", c, 32'(busy), 32'(ex_busy[c]));
        cmp("wb_done", c, 32'(wb_done), 32'(ex_wb_done[c]));
        cmp("ext_ready", c, 32'(ext_ready), 32'(ex_ext_ready[c]));
        cmp("ext_err", c, 32'(ext_err), 32'(ex_ext_err[c]));
        cmp("err_timeout", c, 32'(err_timeout), 32'(m_err));
        cmp("wb_stall", c, 32'(wb_stall), 32'(in_wb_req[c] && !ex_resp_wb[c]));
        if (m_rd_known) cmp("ext_rdata", c, 32'(ext_rdata), 32'(m_rd_val));
        if (ex_mem_req[c]) begin
            cmp("mem_we", c, 32'(mem_we), 32'(ex_mem_we[c]));
            cmp("mem_addr", c, 32'(mem_addr), 32'(ex_mem_addr[c]));
            cmp("mem_wdata", c, 32'(mem_wdata), 32'(ex_mem_wdata[c]));
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NCYC) check_cycle(cyc);
    end

    initial begin
        int r;
        int t;
        for (int c = 0; c < NCYC; c++) begin
            in_rst[c] = 1'b0; in_wb_req[c] = 1'b0; in_wb_addr[c] = 8'h00; in_wb_wdata[c] = 8'h00;
            in_ext_valid[c] = 1'b0; in_ext_we[c] = 1'b0; in_ext_addr[c] = 8'h00; in_ext_wdata[c] = 8'h00;
            in_mem_ready[c] = 1'b0; in_mem_rdata[c] = 8'($urandom); in_err_clr[c] = 1'b0;
            ex_mem_req[c] = 1'b0; ex_mem_we[c] = 1'b0; ex_mem_addr[c] = 8'h00; ex_mem_wdata[c] = 8'h00;
            ex_busy[c] = 1'b0; ex_wb_done[c] = 1'b0; ex_resp_wb[c] = 1'b0; ex_ext_ready[c] = 1'b0;
            ex_ext_err[c] = 1'b0; ex_err_set[c] = 1'b0; ex_rd_ev[c] = 0; ex_rd_val[c] = 8'h00;
        end
        in_rst[0] = 1'b1;
        // single WB store, memory ready in first request cycle
        t = access(3, 3, 0, 8'h12, 8'hA5, 0, 8'h00);
        // ext read answered after 3 wait cycles
        t = access(7, 7, 1, 8'h40, 8'h00, 3, 8'h3C);
        // simultaneous requests: WB first, ext right after
        t = access(14, 14, 0, 8'h21, 8'h5A, 1, 8'h00);
        t = access(14, t + 1, 1, 8'h80, 8'h00, 0, 8'hC3);
        // WB abort with same-edge clear, ready on the last allowed cycle, ext read abort
        t = access(22, 22, 0, 8'h33, 8'h11, 99, 8'h00);
        in_err_clr[37] = 1'b1;
        t = access(40, 40, 2, 8'h44, 8'h99, 14, 8'h00);
        in_err_clr[60] = 1'b1;
        t = access(62, 62, 1, 8'h55, 8'h00, 99, 8'h00);
        // reset in the middle of a store, then the store is re-presented
        t = access(85, 85, 0, 8'h66, 8'h77, 5, 8'h00);
        kill(88, 95);
        t = access(90, 90, 0, 8'h55, 8'h66, 0, 8'h00);
        // back-to-back stores against a waiting ext read
        r = 96;
        for (int i = 0; i < 3; i++) r = access(r, r, 0, 8'(8'hA0 + i), 8'(8'h10 + i), 0, 8'h00) + 1;
`ifdef DMEM_ARB_AGING_EN
        t = access(96, r, 1, 8'h99, 8'h00, 0, 8'h77);
        t = access(r, t + 1, 0, 8'hA3, 8'h13, 0, 8'h00);
`else
        t = access(r, r, 0, 8'hA3, 8'h13, 0, 8'h00);
        t = access(96, t + 1, 1, 8'h99, 8'h00, 0, 8'h77);
`endif

        cyc = 0;
        apply(0);
        for (int c = 1; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            apply(c);
            case (c)
                1: begin
                    cmp("lit_reset_busy", c, 32'(busy), 32'd0);
                    cmp("lit_reset_mem_req", c, 32'(mem_req), 32'd0);
                    cmp("lit_reset_err", c, 32'(err_timeout), 32'd0);
                end
                4: begin
                    cmp("lit_t1_mem_req", c, 32'(mem_req), 32'd1);
                    cmp("lit_t1_addr", c, 32'(mem_addr), 32'h12);
                    cmp("lit_t1_wdata", c, 32'(mem_wdata), 32'hA5);
                    cmp("lit_t1_we", c, 32'(mem_we), 32'd1);
                end
                5: begin
                    cmp("lit_t1_done", c, 32'(wb_done), 32'd1);
                    cmp("lit_t1_stall", c, 32'(wb_stall), 32'd0);
                end
                12: begin
                    cmp("lit_t2_ready", c, 32'(ext_ready), 32'd1);
                    cmp("lit_t2_rdata", c, 32'(ext_rdata), 32'h3C);
                    cmp("lit_t2_err", c, 32'(ext_err), 32'd0);
                end
                38: begin
                    cmp("lit_t4_err", c, 32'(err_timeout), 32'd1);
                    cmp("lit_t4_done", c, 32'(wb_done), 32'd1);
                end
                61: cmp("lit_t4_clr", c, 32'(err_timeout), 32'd0);
                78: cmp("lit_t4_ext_err", c, 32'(ext_err), 32'd1);
                89: begin
                    cmp("lit_t5_mem_req", c, 32'(mem_req), 32'd0);
                    cmp("lit_t5_busy", c, 32'(busy), 32'd0);
                    cmp("lit_t5_err", c, 32'(err_timeout), 32'd0);
                end
`ifdef DMEM_ARB_AGING_EN
                106: cmp("lit_t6_owner_addr", c, 32'(mem_addr), 32'h99);
`else
                106: cmp("lit_t6_owner_addr", c, 32'(mem_addr), 32'hA3);
`endif
                default: ;
            endcase
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
